// File: rtl/pwm_pkg.sv
// Shared types and defaults for the counter-driven PWM generator.
// The FSM state and the step classification enums live here so that every block agrees on their encodings.
package pwm_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    SYNC,
    RUN
  } pwm_state_t;

  // How the sampled count moved relative to the previous sample.
  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_INC,
    STEP_WRAP,
    STEP_BAD
  } step_class_t;

endpackage

// File: rtl/count_pwm_gen_if.sv
// Duty-update handshake bundle between a duty source (master) and the PWM generator (slave).
interface count_pwm_gen_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] duty_data;
  logic             duty_valid;
  logic             duty_ready;

  modport master (
    output duty_data,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_data,
    input  duty_valid,
    output duty_ready
  );

endinterface

// File: rtl/count_step_chk.sv
// Classifies the move from the previous count sample to the current one.
// This block is purely combinational: hold, +1 step, wrap to zero, or anything else as an error.
module count_step_chk
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] count_q,
  output logic             is_hold,
  output logic             is_step,
  output logic             is_wrap,
  output logic             is_err
);

  logic [WIDTH-1:0] count_inc;

  assign count_inc = count_q + WIDTH'(1);

  assign is_hold = (count == count_q);
  // A jump to zero from any non-zero value is a wrap; this also covers an upstream restart mid-period.
  assign is_wrap = (count == '0) && (count_q != '0);
  assign is_step = (count == count_inc) && (count != '0);
  assign is_err  = !(is_hold || is_step || is_wrap);

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator that follows a free-running upstream counter and produces a period tick on each wrap.
// Duty updates are double-buffered so that they only take effect on a wrap; illegal count steps raise a sticky flag.
module count_pwm_gen
  import pwm_pkg::*;
#(
  parameter int             WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DUTY_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  count_pwm_gen_if.slave   duty_if,
  output logic             pwm_out,
  output logic             period_tick,
  output logic             err_skip
);

  pwm_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_duty_q, active_duty_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pending_full_q, pending_full_d;
  logic             pwm_q, pwm_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic        is_hold, is_step, is_wrap, is_err;
  step_class_t step_class;
  logic        wrap_seen;
  logic        xfer;

  count_step_chk #(
    .WIDTH (WIDTH)
  ) u_step_chk (
    .count   (count),
    .count_q (count_q),
    .is_hold (is_hold),
    .is_step (is_step),
    .is_wrap (is_wrap),
    .is_err  (is_err)
  );

  always_comb begin
    step_class = STEP_BAD;
    if (is_wrap)      step_class = STEP_WRAP;
    else if (is_err)  step_class = STEP_BAD;
    else if (is_step) step_class = STEP_INC;
    else if (is_hold) step_class = STEP_HOLD;
  end

  // The first sample after reset has no valid predecessor, so classification only counts in RUN.
  assign wrap_seen = (state_q == RUN) && (step_class == STEP_WRAP);
  assign xfer      = duty_if.duty_valid && !pending_full_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d        = RUN;
    count_d        = count;
    active_duty_d  = active_duty_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    err_d          = err_q;
    tick_d         = wrap_seen;

    // Draining the slot at a wrap and accepting a transfer are exclusive: a transfer needs the slot empty.
    if (wrap_seen && pending_full_q) begin
      active_duty_d  = pending_q;
      pending_full_d = 1'b0;
    end
    if (xfer) begin
      pending_d      = duty_if.duty_data;
      pending_full_d = 1'b1;
    end

    if ((state_q == RUN) && (step_class == STEP_BAD)) begin
      err_d = 1'b1;
    end

    // Compare against the duty being installed at this edge so a new duty governs the count==0 sample.
    pwm_d = (count < active_duty_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= SYNC;
      count_q        <= '0;
      active_duty_q  <= DUTY_INIT;
      // NOTE: the pending slot is reset along with its full flag so that no stale duty can leak after reset.
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      pwm_q          <= 1'b0;
      tick_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      active_duty_q  <= active_duty_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      pwm_q          <= pwm_d;
      tick_q         <= tick_d;
      err_q          <= err_d;
    end
  end

  assign duty_if.duty_ready = !pending_full_q;
  assign pwm_out            = pwm_q;
  assign period_tick        = tick_q;
  assign err_skip           = err_q;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Scoreboard bench for count_pwm_gen: the stimulus process pushes expected outputs from a behavioural
// model, and an independent monitor pops and compares them one cycle later.
module tb_count_pwm_gen;
  import pwm_pkg::*;

  localparam int W      = 4;
  localparam int PERIOD = 1 << W;

  typedef struct packed {
    logic pwm;
    logic tick;
    logic err;
    logic ready;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] count;
  logic         pwm_out;
  logic         period_tick;
  logic         err_skip;

  count_pwm_gen_if #(.WIDTH(W)) duty_if ();

  count_pwm_gen #(
    .WIDTH     (W),
    .DUTY_INIT ('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .duty_if     (duty_if.slave),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .err_skip    (err_skip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  // Reference model state: what the generator should be holding, described by the rules, not by registers.
  bit   m_synced;
  int   m_prev;
  int   m_active;
  int   m_pend[$];
  bit   m_err;
  int   cnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_synced = 1'b0;
    m_prev   = 0;
    m_active = 0;
    m_pend.delete();
    m_err    = 1'b0;
  endtask

  // Drive one cycle of inputs (no waiting) and queue what the outputs must be after the next edge.
  task automatic step(input int c, input bit v, input int d);
    exp_t e;
    bit   room;
    bit   tick;
    room = (m_pend.size() == 0);
    count              = W'(c);
    duty_if.duty_valid = v;
    duty_if.duty_data  = W'(d);
    tick = 1'b0;
    if (!m_synced) begin
      m_synced = 1'b1;
    end else if (c == 0 && m_prev != 0) begin
      tick = 1'b1;
      if (m_pend.size() != 0) m_active = m_pend.pop_front();
    end else if (!(c == m_prev || (c == (m_prev + 1) % PERIOD && c != 0))) begin
      m_err = 1'b1;
    end
    m_prev = c;
    if (v && room) m_pend.push_back(d);
    e.pwm   = (c < m_active);
    e.tick  = tick;
    e.err   = m_err;
    e.ready = (m_pend.size() == 0);
    exp_q.push_back(e);
  endtask

  task automatic cycle(input int c, input bit v = 1'b0, input int d = 0);
    @(negedge clk);
    step(c, v, d);
  endtask

  task automatic adv(input bit v = 1'b0, input int d = 0);
    cnt = (cnt + 1) % PERIOD;
    cycle(cnt, v, d);
  endtask

  task automatic adv_to(input int target);
    do adv(); while (cnt != target);
  endtask

  task automatic check_reset_outputs();
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_tick", int'(period_tick), 0);
    check("rst_err", int'(err_skip), 0);
    check("rst_ready", int'(duty_if.duty_ready), 1);
  endtask

  // Assert reset asynchronously between edges, verify outputs clear at once, then release into SYNC at count c.
  task automatic do_reset(input int c);
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    #1 check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cnt = c;
    step(c, 1'b0, 0);
  endtask

  // Monitor: every output sample after an active edge is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pwm_out", int'(pwm_out), int'(e.pwm));
        check("period_tick", int'(period_tick), int'(e.tick));
        check("err_skip", int'(err_skip), int'(e.err));
        check("duty_ready", int'(duty_if.duty_ready), int'(e.ready));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst                = 1'b0;
    count              = '0;
    duty_if.duty_valid = 1'b0;
    duty_if.duty_data  = '0;
    model_reset();
    #2 check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    step(0, 1'b0, 0);

    // Free-running with the reset duty of zero.
    repeat (2 * PERIOD) adv();

    // Duty 5 loaded mid-period, applied at the next wrap.
    adv_to(6);
    adv(1'b1, 5);
    repeat (2 * PERIOD + 4) adv();

    // Duty 3 offered exactly on the wrap cycle: pending until the following wrap.
    adv_to(15);
    cnt = 0;
    cycle(0, 1'b1, 3);
    repeat (2 * PERIOD + 2) adv();

    // Upstream restart at count 9 acts as a wrap and installs the pending duty.
    adv_to(2);
    adv(1'b1, 10);
    adv_to(9);
    cnt = 0;
    cycle(0);
    repeat (PERIOD + 4) adv();

    // Illegal jump 4 -> 7 sets the sticky error.
    adv_to(4);
    cnt = 7;
    cycle(7);
    repeat (PERIOD + 4) adv();

    // Duty at the maximum, with a held valid while the slot is full.
    adv(1'b1, 15);
    adv(1'b1, 9);
    adv(1'b1, 9);
    repeat (2 * PERIOD) adv();

    // Pending duty 12 taken on a wrap, then reset while tick, pwm and err are all high.
    adv_to(15);
    cnt = 0;
    cycle(0, 1'b1, 12);
    do_reset(6);
    repeat (PERIOD + 4) adv();

    // Random traffic: holds and restarts only, then occasional illegal jumps.
    for (int i = 0; i < 600; i++) begin
      bit v;
      int d;
      r = int'($urandom_range(99));
      v = ($urandom_range(2) == 0);
      case ($urandom_range(3))
        0:       d = 0;
        1:       d = PERIOD - 1;
        default: d = int'($urandom_range(PERIOD - 1));
      endcase
      if (r < 8) begin
        cycle(cnt, v, d);
      end else if (r < 12) begin
        cnt = 0;
        cycle(0, v, d);
      end else if (r < 14 && i >= 400) begin
        cnt = (cnt + int'($urandom_range(PERIOD - 2, 2))) % PERIOD;
        cycle(cnt, v, d);
      end else begin
        adv(v, d);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
